// File: rtl/opl_mix_seq_if.sv
// Volume-write bus and mixed-sample output bus for opl_mix_seq.
// The master side (controller/DAC path) writes volumes and receives samples.
interface opl_mix_seq_if #(
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 8
);
    logic                       vol_wr;
    logic [3:0]                 vol_addr;
    logic [VOL_W-1:0]           vol_din;
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
    logic                       sample_stb;

    modport master (
        output vol_wr, vol_addr, vol_din,
        input  left, right, sample_stb
    );

    modport slave (
        input  vol_wr, vol_addr, vol_din,
        output left, right, sample_stb
    );
endinterface

// File: rtl/opl_mix_seq.sv
// N-channel stereo mixer and sample-rate sequencer.
// Each frame snapshots all channel samples and a volume shadow on the rate
// tick, accumulates one scaled channel per clock, then shifts and saturates.
// Optional build macro: OPL_MIX_CLIP_CNT_EN enables the clipped-frame counter.
module opl_mix_seq #(
    parameter int OPLCLK   = 50000000,
    parameter int RATE     = 44100,
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_left,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_right,
    opl_mix_seq_if.slave                 bus,
    output logic                         overrun,
    output logic [7:0]                   clip_cnt
);
    localparam int TICK   = OPLCLK / RATE;
    localparam int CNT_W  = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(CHANNELS) + 1;
    localparam logic [3:0] LAST = 4'(CHANNELS - 1);
    localparam logic [VOL_W-1:0] UNITY = {1'b1, {(VOL_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) << (SAMPLE_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;

    typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

    state_t                      state, state_nxt;
    logic [1:0]                  rst_sync;
    logic                        rst_n;
    logic [CNT_W-1:0]            tick_cnt;
    logic                        tick;
    logic [VOL_W-1:0]            vol    [CHANNELS];
    logic [VOL_W-1:0]            vol_sh [CHANNELS];
    logic [CHANNELS*SAMPLE_W-1:0] samp_l, samp_r;
    logic signed [ACC_W-1:0]     acc_l, acc_r;
    logic [3:0]                  idx;
    logic [VOL_W-1:0]            vol_sel;
    logic signed [SAMPLE_W-1:0]  s_l, s_r;
    logic signed [PROD_W-1:0]    p_l, p_r;
    logic signed [ACC_W-1:0]     sh_l, sh_r;
    logic                        over_l, under_l, over_r, under_r;
    logic signed [SAMPLE_W-1:0]  sat_l, sat_r;

    // Reset asserts asynchronously, deasserts after two clock edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Frame-rate counter; tick fires while the count is zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              tick_cnt <= '0;
        else if (tick_cnt == CNT_W'(TICK - 1))   tick_cnt <= '0;
        else                                     tick_cnt <= tick_cnt + 1'b1;
    end
    assign tick = (tick_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and strobe
    always_comb begin
        state_nxt      = state;
        bus.sample_stb = 1'b0;
        case (state)
            IDLE: if (tick) state_nxt = ACC;
            ACC:  if (idx == LAST) state_nxt = SAT;
            SAT:  state_nxt = OUT;
            OUT: begin
                bus.sample_stb = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Live volume table and per-frame shadow; a write coinciding with the tick lands in the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                vol[i]    <= UNITY;
                vol_sh[i] <= UNITY;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (bus.vol_wr && bus.vol_addr == 4'(i)) vol[i] <= bus.vol_din;
                if (state == IDLE && tick)
                    vol_sh[i] <= (bus.vol_wr && bus.vol_addr == 4'(i)) ? bus.vol_din : vol[i];
            end
        end
    end

    // Channel select, scaling and saturation
    always_comb begin
        vol_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++)
            if (idx == 4'(i)) vol_sel = vol_sh[i];
        s_l     = samp_l[idx*SAMPLE_W +: SAMPLE_W];
        s_r     = samp_r[idx*SAMPLE_W +: SAMPLE_W];
        p_l     = s_l * $signed({1'b0, vol_sel});
        p_r     = s_r * $signed({1'b0, vol_sel});
        sh_l    = acc_l >>> (VOL_W - 1);
        sh_r    = acc_r >>> (VOL_W - 1);
        over_l  = sh_l > MAXV;
        under_l = sh_l < MINV;
        over_r  = sh_r > MAXV;
        under_r = sh_r < MINV;
        sat_l   = over_l ? SAMPLE_W'(MAXV) : under_l ? SAMPLE_W'(MINV) : SAMPLE_W'(sh_l);
        sat_r   = over_r ? SAMPLE_W'(MAXV) : under_r ? SAMPLE_W'(MINV) : SAMPLE_W'(sh_r);
    end

    // Datapath: snapshot, serial accumulate, output register
    // Outputs load on the SAT->OUT edge so they are already valid while sample_stb is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_l    <= '0;
            samp_r    <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
            bus.left  <= '0;
            bus.right <= '0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    samp_l <= ch_left;
                    samp_r <= ch_right;
                    acc_l  <= '0;
                    acc_r  <= '0;
                    idx    <= '0;
                end
                ACC: begin
                    acc_l <= acc_l + p_l;
                    acc_r <= acc_r + p_r;
                    if (idx != LAST) idx <= idx + 1'b1;
                end
                SAT: begin
                    bus.left  <= sat_l;
                    bus.right <= sat_r;
                end
                default: ;
            endcase
        end
    end

    // Sticky flag for ticks that arrive while a frame is still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     overrun <= 1'b0;
        else if (tick && state != IDLE) overrun <= 1'b1;
    end

`ifdef OPL_MIX_CLIP_CNT_EN
    logic clip_frame;

    // Count frames where either side clamped, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_frame <= 1'b0;
            clip_cnt   <= '0;
        end else begin
            if (state == SAT) clip_frame <= over_l | under_l | over_r | under_r;
            if (state == OUT && clip_frame && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 1'b1;
        end
    end
`else
    assign clip_cnt = '0;
`endif

endmodule
